rom_loadable: RTL

- Parametrised successor to the fixed 16-bit program ROM blocks; a synchronous-read word ROM whose contents are loaded at run time over a byte-wide download port instead of being compiled in.
- Sits between the CPU/video address decode and the ROM images.
- Adds configurable width, depth and read latency, a read-valid strobe, and a download state machine that assembles bytes into words.
- Read port keeps the existing active-low ce/oe convention.

---
 rtl/rom_loadable.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rom_loadable.sv
// rom_loadable: synchronous-read word ROM whose image is downloaded at run
// time over a byte-wide port. Reads use active-low ce/oe with a one-cycle dv
// strobe. A small FSM pairs even/odd download bytes into words.

module rom_loadable #(
    parameter int AW       = 13,
    parameter int DW       = 16,
    parameter int LATENCY  = 1,
    parameter int HI_FIRST = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [AW-1:0]                    a,
    input  logic                             ce,
    input  logic                             oe,
    output logic [DW-1:0]                    d,
    output logic                             dv,
    input  logic                             dl_en,
    input  logic                             dl_wr,
    input  logic [AW-((DW == 16) ? 0 : 1):0] dl_addr,
    input  logic [7:0]                       dl_data,
    output logic                             busy,
    output logic                             dl_err
);

    localparam int DLW = (DW == 16) ? AW + 1 : AW;

    typedef enum logic [1:0] {IDLE, LO_WAIT, COMMIT} state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      hold_byte;
    logic [DLW-1:0]  hold_addr;
    logic [DW-1:0]   wr_word;
    logic [AW-1:0]   wr_addr;
    logic            dl_en_d;
    logic            set_err;
    logic            load_hold;
    logic            make_word;
    logic            dl_byte;
    logic            pair_ok;
    logic [15:0]     pair_word;
    logic            rd_acc;
    logic [DW-1:0]   q;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem [0:(1 << AW) - 1];

    assign dl_byte   = dl_en & dl_wr;
    assign pair_ok   = (dl_addr == hold_addr + DLW'(1));
    assign pair_word = (HI_FIRST != 0) ? {hold_byte, dl_data} : {dl_data, hold_byte};
    assign rd_acc    = ~ce & ~busy;
    assign d         = oe ? '0 : q;

    // Decide the next download state and which side effects this byte causes
    always_comb begin
        state_next = state;
        set_err    = 1'b0;
        load_hold  = 1'b0;
        make_word  = 1'b0;
        case (state)
            IDLE, COMMIT: begin
                state_next = IDLE;
                if (DW == 16 && dl_byte) begin
                    if (!dl_addr[0]) begin
                        load_hold  = 1'b1;
                        state_next = LO_WAIT;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            LO_WAIT: begin
                if (!dl_en) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end else if (dl_wr) begin
                    if (pair_ok) begin
                        make_word  = 1'b1;
                        state_next = COMMIT;
                    end else begin
                        set_err = 1'b1;
                        if (!dl_addr[0]) begin
                            load_hold = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Download state, byte holding, word assembly, busy and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_byte <= '0;
            hold_addr <= '0;
            wr_word   <= '0;
            wr_addr   <= '0;
            dl_en_d   <= 1'b0;
            busy      <= 1'b0;
            dl_err    <= 1'b0;
        end else begin
            state   <= state_next;
            dl_en_d <= dl_en;
            busy    <= dl_en | (state != IDLE);
            dl_err  <= (dl_err & ~(dl_en & ~dl_en_d)) | set_err;
            if (load_hold) begin
                hold_byte <= dl_data;
                hold_addr <= dl_addr;
            end
            if (make_word) begin
                wr_word <= pair_word[DW-1:0];
                wr_addr <= dl_addr[DLW-1:DLW-AW];
            end
        end
    end

    generate
        if (DW == 16) begin : g_word_write
            assign mem_we    = (state == COMMIT);
            assign mem_waddr = wr_addr;
            assign mem_wdata = wr_word;
        end else begin : g_byte_write
            assign mem_we    = dl_byte;
            assign mem_waddr = dl_addr[AW-1:0];
            assign mem_wdata = DW'(dl_data);
        end
    endgenerate

    // Memory array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic [DW-1:0] s_q;
            logic          s_v;
            // Two-stage read: array register followed by an output register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s_q <= '0;
                    s_v <= 1'b0;
                    q   <= '0;
                    dv  <= 1'b0;
                end else begin
                    s_v <= rd_acc;
                    dv  <= s_v;
                    if (rd_acc) begin
                        s_q <= mem[a];
                    end
                    if (s_v) begin
                        q <= s_q;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read: q follows accepted reads, otherwise holds
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q  <= '0;
                    dv <= 1'b0;
                end else begin
                    dv <= rd_acc;
                    if (rd_acc) begin
                        q <= mem[a];
                    end
                end
            end
        end
    endgenerate

endmodule
